// File: rtl/note_dispatcher.sv
// Polyphonic note dispatcher: hands each song_reader note to the lowest free voice,
// times its duration in beats, and pulses note_done so song_reader can advance.
module note_dispatcher #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  beat,
    input  logic                  new_note,
    input  logic [NOTE_W-1:0]     note,
    input  logic [DUR_W-1:0]      duration,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [DUR_W-1:0]      voice_duration,
    output logic                  note_done,
    output logic [NUM_VOICES-1:0] voices_active,
    output logic                  stall
);

    typedef enum logic [2:0] {
        S_IDLE, S_ALLOC, S_WAIT_VOICE, S_HOLD, S_ADVANCE
    } state_t;

    state_t                  state_q, state_d;
    logic [NOTE_W-1:0]       pending_note_q, pending_note_d;
    logic [DUR_W-1:0]        pending_dur_q, pending_dur_d;
    logic [DUR_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [NUM_VOICES-1:0]   alloc_q, alloc_d;

    logic [NUM_VOICES-1:0]   free;
    logic [NUM_VOICES-1:0]   grant;
    logic [NUM_VOICES:0]     taken;
    logic                    in_alloc;
    logic                    is_rest;
    logic                    load_fire;

    // A voice finishing this cycle counts as free, so it can be reloaded immediately.
    assign free     = ~alloc_q | voice_done;
    assign taken[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_prio
            assign grant[gi]   = free[gi] & ~taken[gi];
            assign taken[gi+1] = taken[gi] | free[gi];
        end
    endgenerate

    assign in_alloc  = (state_q == S_ALLOC) || (state_q == S_WAIT_VOICE);
    assign is_rest   = (pending_note_q == '0);
    assign load_fire = in_alloc && !is_rest && taken[NUM_VOICES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pending_note_q <= '0;
            pending_dur_q  <= '0;
            beat_cnt_q     <= '0;
            alloc_q        <= '0;
        end else begin
            state_q        <= state_d;
            pending_note_q <= pending_note_d;
            pending_dur_q  <= pending_dur_d;
            beat_cnt_q     <= beat_cnt_d;
            alloc_q        <= alloc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pending_note_d = pending_note_q;
        pending_dur_d  = pending_dur_q;
        beat_cnt_d     = beat_cnt_q;
        // Clear-then-set ordering lets a finishing voice be re-loaded in the same cycle.
        alloc_d        = (alloc_q & ~voice_done) | voice_load;
        case (state_q)
            S_IDLE: begin
                if (new_note) begin
                    pending_note_d = note;
                    pending_dur_d  = duration;
                    state_d        = S_ALLOC;
                end
            end
            S_ALLOC, S_WAIT_VOICE: begin
                if (is_rest || taken[NUM_VOICES]) begin
                    beat_cnt_d = pending_dur_q;
                    state_d    = (pending_dur_q == '0) ? S_ADVANCE : S_HOLD;
                end else begin
                    state_d = S_WAIT_VOICE;
                end
            end
            S_HOLD: begin
                if (beat_cnt_q == '0) begin
                    state_d = S_ADVANCE;
                end else if (beat && play) begin
                    beat_cnt_d = beat_cnt_q - DUR_W'(1);
                end
            end
            S_ADVANCE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        voice_load     = load_fire ? grant : '0;
        voice_note     = load_fire ? pending_note_q : '0;
        voice_duration = load_fire ? pending_dur_q : '0;
        note_done      = (state_q == S_ADVANCE);
        stall          = in_alloc && !is_rest && !taken[NUM_VOICES];
        voices_active  = alloc_q;
    end

endmodule

// File: tb/tb_note_dispatcher.sv
// Directed bench for note_dispatcher: allocation, chords, stalling, rests, pause and reset.
module tb_note_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic       beat;
    logic       new_note;
    logic [5:0] note;
    logic [5:0] duration;
    logic [2:0] voice_done;
    logic [2:0] voice_load;
    logic [5:0] voice_note;
    logic [5:0] voice_duration;
    logic       note_done;
    logic [2:0] voices_active;
    logic       stall;

    int tests_run = 0;
    int failures  = 0;

    note_dispatcher #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat),
        .new_note(new_note), .note(note), .duration(duration),
        .voice_done(voice_done), .voice_load(voice_load),
        .voice_note(voice_note), .voice_duration(voice_duration),
        .note_done(note_done), .voices_active(voices_active), .stall(stall)
    );

    always #5 clk = ~clk;

    // Advance one clock; pulse inputs drop after the edge and outputs settle before return.
    task automatic tick();
        @(posedge clk);
        #1;
        new_note   = 1'b0;
        beat       = 1'b0;
        voice_done = 3'b000;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; beat = 1'b0; new_note = 1'b0;
        note = '0; duration = '0; voice_done = '0;
        tick(); tick();
        tests_run++; if (voice_load !== 3'b000) begin failures++; $display("FAIL reset_voice_load got=%b exp=000", voice_load); end
        tests_run++; if (voices_active !== 3'b000) begin failures++; $display("FAIL reset_active got=%b exp=000", voices_active); end
        tests_run++; if (note_done !== 1'b0) begin failures++; $display("FAIL reset_note_done got=%b exp=0", note_done); end
        tests_run++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        tests_run++; if (voice_note !== 6'd0 || voice_duration !== 6'd0) begin failures++; $display("FAIL reset_buses got=%0d/%0d exp=0/0", voice_note, voice_duration); end
        reset = 1'b0;
        tick();
        $display("[TB] reset released");
    endtask

    task automatic test_single_note();
        int done_k = -1;
        int done_cnt = 0;
        int bad_active = 0;
        new_note = 1'b1; note = 6'd20; duration = 6'd4;
        #1;
        tick();
        tests_run++; if (voice_load !== 3'b001) begin failures++; $display("FAIL single_load got=%b exp=001", voice_load); end
        tests_run++; if (voice_note !== 6'd20 || voice_duration !== 6'd4) begin failures++; $display("FAIL single_buses got=%0d/%0d exp=20/4", voice_note, voice_duration); end
        tick();
        for (int k = 0; k < 25; k++) begin
            beat = (k % 4 == 3);
            #1;
            if (note_done) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (voices_active !== 3'b001) bad_active++;
            tick();
        end
        tests_run++; if (done_k !== 17) begin failures++; $display("FAIL single_done_cycle got=%0d exp=17", done_k); end
        tests_run++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
        tests_run++; if (bad_active !== 0) begin failures++; $display("FAIL single_active_held got=%0d bad cycles exp=0", bad_active); end
        voice_done = 3'b001;
        #1;
        tick();
        tests_run++; if (voices_active !== 3'b000) begin failures++; $display("FAIL single_release got=%b exp=000", voices_active); end
        voice_done = 3'b100;
        #1;
        tick();
        tests_run++; if (voices_active !== 3'b000) begin failures++; $display("FAIL unalloc_done got=%b exp=000", voices_active); end
        $display("[TB] single note 20 dur 4 done at hold cycle %0d", done_k);
    endtask

    task automatic test_chord();
        logic [5:0] notes [3];
        logic [2:0] exp_load;
        notes[0] = 6'd10; notes[1] = 6'd14; notes[2] = 6'd17;
        for (int i = 0; i < 3; i++) begin
            new_note = 1'b1; note = notes[i]; duration = 6'd0;
            #1;
            tick();
            exp_load = 3'b001 << i;
            tests_run++; if (voice_load !== exp_load || voice_note !== notes[i]) begin failures++; $display("FAIL chord_load%0d got=%b/%0d exp=%b/%0d", i, voice_load, voice_note, exp_load, notes[i]); end
            tick();
            tests_run++; if (note_done !== 1'b1) begin failures++; $display("FAIL chord_done%0d got=%b exp=1", i, note_done); end
            tick();
            $display("[TB] chord note %0d loaded on voice %0d", notes[i], i);
        end
        tests_run++; if (voices_active !== 3'b111) begin failures++; $display("FAIL chord_active got=%b exp=111", voices_active); end
    endtask

    task automatic test_stall();
        new_note = 1'b1; note = 6'd25; duration = 6'd0;
        #1;
        tick();
        tests_run++; if (stall !== 1'b1 || voice_load !== 3'b000) begin failures++; $display("FAIL stall_alloc got=%b/%b exp=1/000", stall, voice_load); end
        tick(); tick();
        tests_run++; if (stall !== 1'b1 || voice_load !== 3'b000) begin failures++; $display("FAIL stall_wait got=%b/%b exp=1/000", stall, voice_load); end
        voice_done = 3'b010;
        #1;
        tests_run++; if (voice_load !== 3'b010 || voice_note !== 6'd25) begin failures++; $display("FAIL stall_grant got=%b/%0d exp=010/25", voice_load, voice_note); end
        tests_run++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_drop got=%b exp=0", stall); end
        tick();
        tests_run++; if (note_done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", note_done); end
        tests_run++; if (voices_active !== 3'b111) begin failures++; $display("FAIL stall_reload_active got=%b exp=111", voices_active); end
        tick();
        $display("[TB] stalled note 25 granted voice 1");
    endtask

    task automatic test_rest();
        int done_k = -1;
        int loads = 0;
        int bad_active = 0;
        new_note = 1'b1; note = 6'd0; duration = 6'd2;
        #1;
        tick();
        tests_run++; if (voice_load !== 3'b000 || stall !== 1'b0) begin failures++; $display("FAIL rest_alloc got=%b/%b exp=000/0", voice_load, stall); end
        tick();
        for (int k = 0; k < 10; k++) begin
            beat = (k == 1 || k == 3);
            #1;
            if (note_done && done_k < 0) done_k = k;
            if (voice_load !== 3'b000) loads++;
            if (voices_active !== 3'b111) bad_active++;
            tick();
        end
        tests_run++; if (done_k !== 5) begin failures++; $display("FAIL rest_done_cycle got=%0d exp=5", done_k); end
        tests_run++; if (loads !== 0 || bad_active !== 0) begin failures++; $display("FAIL rest_no_load got=%0d loads %0d bad exp=0/0", loads, bad_active); end
        $display("[TB] rest dur 2 done at hold cycle %0d", done_k);
    endtask

    task automatic test_pause();
        int done_k = -1;
        voice_done = 3'b111;
        #1;
        tick();
        tests_run++; if (voices_active !== 3'b000) begin failures++; $display("FAIL pause_release got=%b exp=000", voices_active); end
        new_note = 1'b1; note = 6'd30; duration = 6'd3;
        #1;
        tick();
        tests_run++; if (voice_load !== 3'b001) begin failures++; $display("FAIL pause_load got=%b exp=001", voice_load); end
        tick();
        for (int k = 0; k < 35; k++) begin
            play = !(k >= 2 && k <= 21);
            beat = (k % 2 == 1);
            #1;
            if (note_done && done_k < 0) done_k = k;
            tick();
        end
        play = 1'b1;
        tests_run++; if (done_k !== 27) begin failures++; $display("FAIL pause_done_cycle got=%0d exp=27", done_k); end
        $display("[TB] paused note 30 dur 3 done at hold cycle %0d", done_k);
    endtask

    task automatic test_reset_hold();
        int dones = 0;
        new_note = 1'b1; note = 6'd40; duration = 6'd5;
        #1;
        tick();
        tests_run++; if (voice_load !== 3'b010) begin failures++; $display("FAIL hold_load got=%b exp=010", voice_load); end
        tick(); tick();
        reset = 1'b1;
        #1;
        tests_run++; if (voices_active !== 3'b000) begin failures++; $display("FAIL async_reset_active got=%b exp=000", voices_active); end
        tests_run++; if (voice_load !== 3'b000 || note_done !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL async_reset_outs got=%b/%b/%b exp=000/0/0", voice_load, note_done, stall); end
        for (int k = 0; k < 5; k++) begin
            beat = 1'b1;
            #1;
            if (note_done) dones++;
            tick();
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat = 1'b1;
            #1;
            if (note_done) dones++;
            tick();
        end
        tests_run++; if (dones !== 0) begin failures++; $display("FAIL reset_abandon got=%0d note_done exp=0", dones); end
        new_note = 1'b1; note = 6'd7; duration = 6'd0;
        #1;
        tick();
        tests_run++; if (voice_load !== 3'b001 || voice_note !== 6'd7) begin failures++; $display("FAIL post_reset_load got=%b/%0d exp=001/7", voice_load, voice_note); end
        tick(); tick();
        $display("[TB] reset during hold abandoned note 40");
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_chord();
        test_stall();
        test_rest();
        test_pause();
        test_reset_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/note_dispatcher.md
Name: note_dispatcher

Overview:
- Sits between song_reader and a bank of NUM_VOICES note players; adds polyphony to the music player.
- Accepts each note from song_reader, allocates a free voice, loads it, then times the note's duration in beats.
- Generates the note_done handshake that advances song_reader.
- A duration of 0 means chord: song_reader advances immediately, so notes stack across voices.

Parameters:
NUM_VOICES, 3, number of note-player voices managed
NOTE_W, 6, note code width; note 0 = rest
DUR_W, 6, duration width in beats

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
play  input  1  1 = beats counted; 0 = paused, beat counting frozen
beat  input  1  one-cycle beat tick
new_note  input  1  one-cycle pulse from song_reader; note/duration valid
note  input  NOTE_W  note code from song_reader
duration  input  DUR_W  beats until song_reader advances
voice_done  input  NUM_VOICES  one-cycle pulse per voice when its player finishes
voice_load  output  NUM_VOICES  one-hot, one-cycle load strobe to the selected voice
voice_note  output  NOTE_W  shared note bus, valid with voice_load
voice_duration  output  DUR_W  shared duration bus, valid with voice_load
note_done  output  1  one-cycle pulse: song_reader may present next note
voices_active  output  NUM_VOICES  allocation bitmap
stall  output  1  high while waiting for a free voice

Behaviour:
- Reset (async) clears all outputs, the allocation bitmap, pending registers and beat counter, and sets the state to IDLE. Reset mid-note abandons the note with no note_done pulse.
- States are IDLE, ALLOC, WAIT_VOICE, HOLD and ADVANCE.
- IDLE:
  - On new_note, latch note and duration into pending_note and pending_dur, then go to ALLOC.
  - new_note in any other state is ignored.
- ALLOC / WAIT_VOICE (both evaluated each cycle):
  - Define free[i] = ~alloc[i] | voice_done[i]. A voice completing in the same cycle is reusable that cycle.
  - If pending_note == 0 (rest): no load. Go to HOLD, or to ADVANCE if pending_dur == 0.
  - Else if any free[i]: choose the lowest index i.
    - Pulse voice_load[i] for exactly 1 cycle.
    - Drive voice_note = pending_note and voice_duration = pending_dur in that cycle; both buses are 0 otherwise.
    - Set alloc[i].
    - Go to HOLD, or to ADVANCE if pending_dur == 0.
  - Else go to (or stay in) WAIT_VOICE with stall = 1. Stall has no timeout.
- HOLD:
  - beat_cnt is loaded with pending_dur on entry.
  - Decrement only when beat & play.
  - When the counter reaches 0 (the decrement from 1), go to ADVANCE on the next edge.
  - play = 0 freezes the count; no beats are lost or accumulated.
- ADVANCE: note_done = 1 for exactly 1 cycle, then go to IDLE.
- Latency:
  - new_note to voice_load is 1 cycle when a voice is free.
  - For duration 0, voice_load to note_done is 1 cycle.
- alloc[i] is cleared on voice_done[i] in any state. A same-cycle voice_done[i] and a re-load of voice i leaves alloc[i] = 1.
- voice_done on an unallocated voice is ignored.
- voices_active = alloc register.
- Widths: beat_cnt is DUR_W bits. No arithmetic wraps, because decrement is never applied at 0.

Test Plan:
- Reset, then new_note with note=20, dur=4, play=1, beat every 4 cycles -> voice_load=001 one cycle after new_note, voice_note=20; note_done after 4th beat; voices_active=001 until voice_done[0].
- Chord: three new_notes (10, 14, 17), dur=0, each after note_done -> voice_load 001, 010, 100; note_done 1 cycle after each load; voices_active=111.
- Fourth note with all voices busy -> stall=1, no load; voice_done=010 pulse -> voice_load=010 that same cycle, stall drops.
- Rest note=0, dur=2 -> no voice_load; note_done after 2 beats; voices_active unchanged.
- note=30, dur=3; play=0 after 1 beat for 20 cycles, beats continuing -> count frozen; note_done only after 2 more beats once play=1.
- Assert reset during HOLD -> all outputs 0 immediately, no note_done; next new_note allocates voice 0.
